// File: rtl/omicron_spi_pkg.sv
// Shared constants, header layout and state encoding for the fabric-side SPI flash reader.
package omicron_spi_pkg;

    localparam logic [7:0]  READ_OPCODE = 8'h03;
    localparam int unsigned ADDR_W      = 24;
    localparam int unsigned HDR_W       = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        STALL,
        DESEL
    } state_t;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [ADDR_W-1:0] addr;
    } spi_hdr_t;

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: CLK_DIV-cycle half-period counter with pause, one-cycle edge strobes and idle-high SCK.
module spi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic run,
    input  logic pause,
    input  logic clear,
    output logic fall_strobe_c,
    output logic rise_strobe_c,
    output logic flash_clk
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;
    logic             tick_c;

    // Strobes mark the clock edge on which flash_clk will toggle.
    always_comb begin
        tick_c        = run && !pause && (cnt == CNT_W'(CLK_DIV - 1));
        fall_strobe_c = tick_c && flash_clk;
        rise_strobe_c = tick_c && !flash_clk;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            cnt       <= '0;
            flash_clk <= 1'b1;
        end else if (!run || pause) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt       <= '0;
            flash_clk <= !flash_clk;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-3 READ (0x03) master: sends opcode+address, streams bytes out through a 2-deep buffer.
module spi_flash_reader
    import omicron_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CS_HIGH_CYC = 4,
    parameter int unsigned LEN_W       = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic [7:0]        data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              flash_cs,
    output logic              flash_clk,
    output logic              flash_si,
    input  logic              flash_so
);

    localparam int unsigned BIT_W   = 5;
    localparam int unsigned DESEL_W = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

    state_t             state;
    logic [HDR_W-1:0]   hdr_sr;
    logic [7:0]         rx_sr;
    logic               pending;
    logic [LEN_W-1:0]   byte_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DESEL_W-1:0] desel_cnt;

    spi_hdr_t   hdr_c;
    logic       fall_c, rise_c;
    logic       run_c, pause_c, clear_c;
    logic       abort_c, out_free_c, byte_done_c, final_c;
    logic [7:0] byte_c;

    always_comb begin
        hdr_c.opcode = READ_OPCODE;
        hdr_c.addr   = cmd_addr;
        run_c        = (state == HDR) || (state == DATA) || (state == STALL);
        pause_c      = (state == STALL);
        abort_c      = abort && (state != IDLE);
        out_free_c   = !data_valid || data_ready;
        byte_c       = {rx_sr[6:0], flash_so};
        byte_done_c  = (state == DATA) && rise_c && (bit_cnt == BIT_W'(7));
        final_c      = (state == DATA) && fall_c && (byte_cnt == '0);
        clear_c      = abort_c || final_c;
    end

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .run           (run_c),
        .pause         (pause_c),
        .clear         (clear_c),
        .fall_strobe_c (fall_c),
        .rise_strobe_c (rise_c),
        .flash_clk     (flash_clk)
    );

    // MSB of the header shifter drives MOSI; it drains to zero for the data phase.
    assign flash_si = hdr_sr[HDR_W-1];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            flash_cs   <= 1'b1;
            hdr_sr     <= '0;
            rx_sr      <= '0;
            pending    <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            desel_cnt  <= '0;
        end else if (abort_c) begin
            state      <= DESEL;
            flash_cs   <= 1'b1;
            data_valid <= 1'b0;
            pending    <= 1'b0;
            hdr_sr     <= '0;
            bit_cnt    <= '0;
            desel_cnt  <= DESEL_W'(CS_HIGH_CYC - 1);
        end else begin
            if ((state == DATA) && rise_c)
                rx_sr <= byte_c;

            // Output register first, shift register as the second slot.
            if (byte_done_c) begin
                if (out_free_c) begin
                    data       <= byte_c;
                    data_valid <= 1'b1;
                end else begin
                    pending <= 1'b1;
                end
            end else if (pending && out_free_c) begin
                data       <= rx_sr;
                data_valid <= 1'b1;
                pending    <= 1'b0;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // The very first falling edge keeps bit 31 on the line.
            if (fall_c && ((state == DATA) || (bit_cnt != '0)))
                hdr_sr <= {hdr_sr[HDR_W-2:0], 1'b0};

            case (state)
                IDLE: begin
                    if (cmd_valid && (cmd_len != '0)) begin
                        state     <= HDR;
                        hdr_sr    <= hdr_c;
                        byte_cnt  <= cmd_len;
                        bit_cnt   <= '0;
                        flash_cs  <= 1'b0;
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                HDR: begin
                    if (rise_c) begin
                        if (bit_cnt == BIT_W'(HDR_W - 1)) begin
                            bit_cnt <= '0;
                            state   <= (pending && !out_free_c) ? STALL : DATA;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (final_c) begin
                        flash_cs  <= 1'b1;
                        state     <= DESEL;
                        desel_cnt <= DESEL_W'(CS_HIGH_CYC - 1);
                    end else if (rise_c) begin
                        if (bit_cnt == BIT_W'(7)) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_cnt - LEN_W'(1);
                            if ((byte_cnt != LEN_W'(1)) && !out_free_c)
                                state <= STALL;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                STALL: begin
                    if (out_free_c)
                        state <= DATA;
                end
                DESEL: begin
                    if (desel_cnt == '0) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        desel_cnt <= desel_cnt - DESEL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
